// File: rtl/food_pkg.sv
// Shared types and helpers for the food manager and its LFSR.
package food_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_CHECK  = 2'd1,
        STATE_SEARCH = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_HEIGHT    = 24;
    localparam int unsigned DEF_POS_W     = 10;
    localparam int unsigned DEF_MAX_LEN   = 15;
    localparam int unsigned DEF_LEN_W     = 4;
    localparam int unsigned DEF_NUM_SNAKE = 2;
    localparam int unsigned DEF_NUM_FOOD  = 2;
    localparam int unsigned DEF_MAX_TRIES = 64;
    localparam logic [15:0] DEF_SEED      = 16'hACE1;

    // Number of playable cells on a WIDTH x HEIGHT board.
    function automatic int unsigned board_cells(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    // LSB of field idx in a flat vector of fw-bit fields.
    function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned fw);
        return idx * fw;
    endfunction

endpackage

// File: rtl/food_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11), reloaded with SEED on reset.
module lfsr_galois
    import food_pkg::*;
#(
    parameter logic [15:0] SEED  = DEF_SEED,
    parameter int unsigned OUT_W = DEF_POS_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] rnd_o
);

    localparam logic [15:0] TAPS = 16'hB400;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Right-shifting Galois step: feedback bit XORs into the tap positions.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ TAPS;
        end
    end

    // Free-running register; only reset reloads the seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/food_manager.sv
// Multi-slot food placement and per-snake scoring, driven by game-step pulses.
module food_manager
    import food_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned HEIGHT    = DEF_HEIGHT,
    parameter int unsigned POS_W     = DEF_POS_W,
    parameter int unsigned MAX_LEN   = DEF_MAX_LEN,
    parameter int unsigned LEN_W     = DEF_LEN_W,
    parameter int unsigned NUM_SNAKE = DEF_NUM_SNAKE,
    parameter int unsigned NUM_FOOD  = DEF_NUM_FOOD,
    parameter int unsigned MAX_TRIES = DEF_MAX_TRIES,
    parameter logic [15:0] SEED      = DEF_SEED
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               step_i,
    input  logic [NUM_SNAKE*MAX_LEN*POS_W-1:0] snake_body_i,
    input  logic [NUM_SNAKE*LEN_W-1:0]         snake_len_i,
    input  logic [NUM_SNAKE*POS_W-1:0]         snake_head_i,
    output logic [NUM_FOOD*POS_W-1:0]          food_pos_o,
    output logic [NUM_FOOD-1:0]                food_valid_o,
    output logic [NUM_SNAKE*LEN_W-1:0]         score_o,
    output logic [NUM_SNAKE-1:0]               eat_pulse_o,
    output logic                               busy_o,
    output logic                               step_dropped_o
);

    localparam int unsigned BOARD_CELLS = board_cells(WIDTH, HEIGHT);
    localparam int unsigned MAX_SCORE   = (1 << LEN_W) - 1;
    localparam int unsigned TRY_W       = $clog2(MAX_TRIES);
    localparam int unsigned NSEG        = NUM_SNAKE * MAX_LEN;

    state_e                         state_q, state_d;
    logic [NUM_FOOD*POS_W-1:0]      food_pos_q, food_pos_d;
    logic [NUM_FOOD-1:0]            food_valid_q, food_valid_d;
    logic [NUM_FOOD-1:0]            pending_q, pending_d;
    logic [NUM_SNAKE*LEN_W-1:0]     score_q, score_d;
    logic [NUM_SNAKE-1:0]           eat_pulse_q, eat_pulse_d;
    logic [TRY_W-1:0]               try_q, try_d;
    logic                           busy_q, busy_d;
    logic                           step_dropped_q, step_dropped_d;

    logic [POS_W-1:0]               cand;
    logic [NSEG-1:0]                seg_hit;
    logic [NUM_SNAKE-1:0]           head_hit;
    logic [NUM_FOOD-1:0]            food_hit;
    logic                           cand_good;
    logic [NUM_FOOD*NUM_SNAKE-1:0]  head_on_food;
    logic [NUM_FOOD*NUM_SNAKE-1:0]  eat_mat;

    lfsr_galois #(
        .SEED  (SEED),
        .OUT_W (POS_W)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .rnd_o (cand)
    );

    // Occupancy comparators: candidate against live body segments, heads and placed foods.
    for (genvar s = 0; s < NUM_SNAKE; s++) begin : g_snake
        assign head_hit[s] = (snake_head_i[field_lsb(s, POS_W) +: POS_W] == cand);
        for (genvar j = 0; j < MAX_LEN; j++) begin : g_seg
            assign seg_hit[s*MAX_LEN+j] =
                (LEN_W'(j) < snake_len_i[field_lsb(s, LEN_W) +: LEN_W]) &&
                (snake_body_i[field_lsb(s*MAX_LEN+j, POS_W) +: POS_W] == cand);
        end
    end

    for (genvar f = 0; f < NUM_FOOD; f++) begin : g_food
        assign food_hit[f] = food_valid_q[f] &&
                             (food_pos_q[field_lsb(f, POS_W) +: POS_W] == cand);
        for (genvar s = 0; s < NUM_SNAKE; s++) begin : g_head
            assign head_on_food[f*NUM_SNAKE+s] =
                (snake_head_i[field_lsb(s, POS_W) +: POS_W] == food_pos_q[field_lsb(f, POS_W) +: POS_W]);
        end
    end

    assign cand_good = (32'(cand) < BOARD_CELLS) && !(|seg_hit) && !(|head_hit) && !(|food_hit);

    // Per valid slot, only the lowest-index snake whose head sits on it eats it.
    always_comb begin
        eat_mat = '0;
        for (int f = 0; f < NUM_FOOD; f++) begin
            if (food_valid_q[f]) begin
                for (int s = NUM_SNAKE - 1; s >= 0; s--) begin
                    if (head_on_food[f*NUM_SNAKE+s]) begin
                        eat_mat[f*NUM_SNAKE +: NUM_SNAKE] = NUM_SNAKE'(1) << s;
                    end
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            STATE_IDLE: begin
                if (step_i) begin
                    state_d = STATE_CHECK;
                end else if (|pending_q) begin
                    state_d = STATE_SEARCH;
                end
            end
            STATE_CHECK:  state_d = (|pending_d) ? STATE_SEARCH : STATE_IDLE;
            STATE_SEARCH: state_d = (|pending_d) ? STATE_SEARCH : STATE_IDLE;
            default:      state_d = STATE_IDLE;
        endcase
    end

    assign busy_d = (state_d != STATE_IDLE);

    // Datapath next values: scoring in CHECK, one placement candidate per SEARCH cycle.
    always_comb begin
        int unsigned sum;
        int unsigned tgt;
        logic        tgt_found;
        food_pos_d     = food_pos_q;
        food_valid_d   = food_valid_q;
        pending_d      = pending_q;
        score_d        = score_q;
        try_d          = try_q;
        eat_pulse_d    = '0;
        step_dropped_d = step_i && (state_q != STATE_IDLE);
        sum            = 0;
        tgt            = 0;
        tgt_found      = 1'b0;
        case (state_q)
            STATE_CHECK: begin
                for (int s = 0; s < NUM_SNAKE; s++) begin
                    sum = 32'(score_q[s*LEN_W +: LEN_W]);
                    for (int f = 0; f < NUM_FOOD; f++) begin
                        if (eat_mat[f*NUM_SNAKE+s]) begin
                            sum            = sum + 1;
                            eat_pulse_d[s] = 1'b1;
                        end
                    end
                    if (sum > MAX_SCORE) begin
                        sum = MAX_SCORE;
                    end
                    score_d[s*LEN_W +: LEN_W] = LEN_W'(sum);
                end
                for (int f = 0; f < NUM_FOOD; f++) begin
                    if (|eat_mat[f*NUM_SNAKE +: NUM_SNAKE]) begin
                        food_valid_d[f] = 1'b0;
                    end
                end
                pending_d = pending_q | ~food_valid_d;
            end
            STATE_SEARCH: begin
                for (int f = NUM_FOOD - 1; f >= 0; f--) begin
                    if (pending_q[f]) begin
                        tgt       = f;
                        tgt_found = 1'b1;
                    end
                end
                if (tgt_found) begin
                    if (cand_good) begin
                        food_pos_d[tgt*POS_W +: POS_W] = cand;
                        food_valid_d[tgt]              = 1'b1;
                        pending_d[tgt]                 = 1'b0;
                        try_d                          = '0;
                    end else if (try_q == TRY_W'(MAX_TRIES - 1)) begin
                        pending_d[tgt] = 1'b0;
                        try_d          = '0;
                    end else begin
                        try_d = try_q + TRY_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            food_pos_q     <= '0;
            food_valid_q   <= '0;
            pending_q      <= '1;
            score_q        <= '0;
            eat_pulse_q    <= '0;
            try_q          <= '0;
            busy_q         <= 1'b0;
            step_dropped_q <= 1'b0;
        end else begin
            food_pos_q     <= food_pos_d;
            food_valid_q   <= food_valid_d;
            pending_q      <= pending_d;
            score_q        <= score_d;
            eat_pulse_q    <= eat_pulse_d;
            try_q          <= try_d;
            busy_q         <= busy_d;
            step_dropped_q <= step_dropped_d;
        end
    end

    assign food_pos_o     = food_pos_q;
    assign food_valid_o   = food_valid_q;
    assign score_o        = score_q;
    assign eat_pulse_o    = eat_pulse_q;
    assign busy_o         = busy_q;
    assign step_dropped_o = step_dropped_q;

endmodule

// File: tb/tb_food_manager.sv
// Directed bench for food_manager: default board plus a tiny 4x2 board for give-up.
module tb_food_manager;

    localparam int unsigned PW  = 10;
    localparam int unsigned ML  = 15;
    localparam int unsigned LW  = 4;
    localparam int unsigned SPW = 3;
    localparam int unsigned SML = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default-parameter instance.
    logic              rst = 1'b1;
    logic              step = 1'b0;
    logic [2*ML*PW-1:0] body = '0;
    logic [2*LW-1:0]   len = '0;
    logic [2*PW-1:0]   head = '0;
    logic [2*PW-1:0]   food_pos;
    logic [1:0]        food_valid;
    logic [2*LW-1:0]   score;
    logic [1:0]        eat_pulse;
    logic              busy;
    logic              step_dropped;

    food_manager dut (
        .clk            (clk),
        .rst            (rst),
        .step_i         (step),
        .snake_body_i   (body),
        .snake_len_i    (len),
        .snake_head_i   (head),
        .food_pos_o     (food_pos),
        .food_valid_o   (food_valid),
        .score_o        (score),
        .eat_pulse_o    (eat_pulse),
        .busy_o         (busy),
        .step_dropped_o (step_dropped)
    );

    // Tiny board instance: 8 cells, one food slot, 16 tries.
    logic               s_rst = 1'b1;
    logic               s_step = 1'b0;
    logic [2*SML*SPW-1:0] s_body = '0;
    logic [2*LW-1:0]    s_len = '0;
    logic [2*SPW-1:0]   s_head = '0;
    logic [SPW-1:0]     s_food_pos;
    logic [0:0]         s_food_valid;
    logic [2*LW-1:0]    s_score;
    logic [1:0]         s_eat;
    logic               s_busy;
    logic               s_drop;

    food_manager #(
        .WIDTH(4), .HEIGHT(2), .POS_W(SPW), .MAX_LEN(SML), .LEN_W(LW),
        .NUM_SNAKE(2), .NUM_FOOD(1), .MAX_TRIES(16), .SEED(16'hACE1)
    ) dut_s (
        .clk            (clk),
        .rst            (s_rst),
        .step_i         (s_step),
        .snake_body_i   (s_body),
        .snake_len_i    (s_len),
        .snake_head_i   (s_head),
        .food_pos_o     (s_food_pos),
        .food_valid_o   (s_food_valid),
        .score_o        (s_score),
        .eat_pulse_o    (s_eat),
        .busy_o         (s_busy),
        .step_dropped_o (s_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] fpos(input int f);
        return food_pos[f*PW +: PW];
    endfunction

    function automatic logic [LW-1:0] sc(input int s);
        return score[s*LW +: LW];
    endfunction

    task automatic set_seg(input int s, input int j, input logic [PW-1:0] p);
        body[(s*ML+j)*PW +: PW] = p;
    endtask

    task automatic set_head(input int s, input logic [PW-1:0] p);
        head[s*PW +: PW] = p;
    endtask

    // True when p is on a live body segment or head of either snake (bench-side view).
    function automatic bit occupied(input logic [PW-1:0] p);
        for (int s = 0; s < 2; s++) begin
            if (head[s*PW +: PW] == p) return 1'b1;
            for (int j = 0; j < int'(len[s*LW +: LW]); j++) begin
                if (body[(s*ML+j)*PW +: PW] == p) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // One-cycle step; afterwards the DUT has taken it (CHECK in progress).
    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (busy !== 1'b0) begin
            if (n >= budget) begin
                ok = 1'b0;
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int  n;
        logic [PW-1:0] p0, p1;
        for (int j = 0; j < 3; j++) begin
            set_seg(0, j, PW'(j));
            set_seg(1, j, PW'(10 + j));
        end
        len = {4'd3, 4'd3};
        set_head(0, 0);
        set_head(1, 10);
        rst = 1'b1;
        tick();
        tick();
        checks++; if (food_valid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", food_valid); end
        checks++; if (food_pos !== '0) begin failures++; $display("FAIL reset_pos got=%h exp=0", food_pos); end
        checks++; if (score !== '0) begin failures++; $display("FAIL reset_score got=%h exp=0", score); end
        checks++; if ({busy, step_dropped, eat_pulse} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, step_dropped, eat_pulse}); end
        rst = 1'b0;
        tick();
        checks++; if ({busy, food_valid} !== 3'b100) begin failures++; $display("FAIL spawn_start busy,valid got=%b exp=100", {busy, food_valid}); end
        n = 0;
        while (!(food_valid === 2'b11 && busy === 1'b0) && n < 2*64+2) begin
            tick();
            n++;
        end
        checks++; if (food_valid !== 2'b11 || busy !== 1'b0) begin failures++; $display("FAIL spawn_done valid=%b busy=%b exp valid=11 busy=0", food_valid, busy); end
        p0 = fpos(0);
        p1 = fpos(1);
        checks++; if (p0 == p1) begin failures++; $display("FAIL spawn_distinct p0=%0d p1=%0d exp different", p0, p1); end
        checks++; if (p0 >= 768 || p1 >= 768) begin failures++; $display("FAIL spawn_range p0=%0d p1=%0d exp <768", p0, p1); end
        checks++; if (occupied(p0) || occupied(p1)) begin failures++; $display("FAIL spawn_free p0=%0d p1=%0d exp off snakes", p0, p1); end
        checks++; if (score !== 8'h00) begin failures++; $display("FAIL spawn_score got=%h exp=00", score); end
    endtask

    task automatic test_eat();
        logic [PW-1:0] old0, old1;
        bit ok;
        old0 = fpos(0);
        old1 = fpos(1);
        set_head(0, old0);
        pulse_step();
        tick();
        checks++; if (eat_pulse !== 2'b01) begin failures++; $display("FAIL eat_pulse got=%b exp=01", eat_pulse); end
        checks++; if (sc(0) !== 4'd1 || sc(1) !== 4'd0) begin failures++; $display("FAIL eat_score got=%h exp=01", score); end
        checks++; if (food_valid !== 2'b10) begin failures++; $display("FAIL eat_valid_drop got=%b exp=10", food_valid); end
        tick();
        checks++; if (eat_pulse !== 2'b00) begin failures++; $display("FAIL eat_pulse_width got=%b exp=00", eat_pulse); end
        wait_idle(70, ok);
        checks++; if (!ok) begin failures++; $display("FAIL eat_timeout busy=%b exp=0", busy); end
        checks++; if (food_valid !== 2'b11) begin failures++; $display("FAIL eat_respawn got=%b exp=11", food_valid); end
        checks++; if (fpos(0) == old0 || occupied(fpos(0)) || fpos(0) >= 768) begin failures++; $display("FAIL eat_newpos got=%0d old=%0d exp new free cell", fpos(0), old0); end
        checks++; if (fpos(1) !== old1) begin failures++; $display("FAIL eat_slot1_kept got=%0d exp=%0d", fpos(1), old1); end
        set_head(0, 0);
    endtask

    task automatic test_tie();
        bit ok;
        set_head(0, fpos(1));
        set_head(1, fpos(1));
        pulse_step();
        tick();
        checks++; if (eat_pulse !== 2'b01) begin failures++; $display("FAIL tie_pulse got=%b exp=01", eat_pulse); end
        checks++; if (sc(0) !== 4'd2 || sc(1) !== 4'd0) begin failures++; $display("FAIL tie_score got=%h exp=02", score); end
        checks++; if (food_valid !== 2'b01) begin failures++; $display("FAIL tie_valid got=%b exp=01", food_valid); end
        wait_idle(70, ok);
        checks++; if (!ok || food_valid !== 2'b11) begin failures++; $display("FAIL tie_respawn valid=%b busy=%b exp 11/0", food_valid, busy); end
        set_head(0, 0);
        set_head(1, 10);
    endtask

    task automatic test_back_to_back();
        bit ok;
        set_head(0, fpos(0));
        pulse_step();
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy got=%b exp=1", busy); end
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++; if (step_dropped !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b exp=1", step_dropped); end
        tick();
        checks++; if (step_dropped !== 1'b0) begin failures++; $display("FAIL drop_pulse_width got=%b exp=0", step_dropped); end
        wait_idle(70, ok);
        set_head(0, 0);
        tick();
        tick();
        checks++; if (!ok || busy !== 1'b0 || food_valid !== 2'b11) begin failures++; $display("FAIL drop_complete busy=%b valid=%b exp 0/11", busy, food_valid); end
        checks++; if (sc(0) !== 4'd3 || sc(1) !== 4'd0) begin failures++; $display("FAIL drop_score got=%h exp=03", score); end
    endtask

    task automatic test_saturate();
        bit ok;
        bit all_ok = 1'b1;
        for (int k = 0; k < 12; k++) begin
            set_head(0, fpos(0));
            pulse_step();
            tick();
            wait_idle(70, ok);
            all_ok &= ok;
            set_head(0, 0);
        end
        checks++; if (!all_ok) begin failures++; $display("FAIL sat_timeout busy=%b exp=0", busy); end
        checks++; if (sc(0) !== 4'd15 || sc(1) !== 4'd0) begin failures++; $display("FAIL sat_preload got=%h exp=0f", score); end
        set_head(0, fpos(0));
        pulse_step();
        tick();
        checks++; if (eat_pulse !== 2'b01) begin failures++; $display("FAIL sat_pulse got=%b exp=01", eat_pulse); end
        checks++; if (sc(0) !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", sc(0)); end
        wait_idle(70, ok);
        set_head(0, 0);
    endtask

    task automatic test_giveup();
        int n;
        logic [SPW-1:0] fp;
        s_len  = '0;
        s_head = {3'd7, 3'd7};
        s_rst  = 1'b1;
        tick();
        s_rst = 1'b0;
        tick();
        n = 0;
        while (!(s_food_valid === 1'b1 && s_busy === 1'b0) && n < 40) begin
            tick();
            n++;
        end
        checks++; if (s_food_valid !== 1'b1 || s_food_pos == 3'd7) begin failures++; $display("FAIL small_spawn valid=%b pos=%0d exp 1/not 7", s_food_valid, s_food_pos); end
        fp = s_food_pos;
        for (int j = 0; j < 8; j++) s_body[j*SPW +: SPW] = SPW'(j);
        s_len  = {4'd0, 4'd8};
        s_head = {3'd7, fp};
        s_step = 1'b1;
        tick();
        s_step = 1'b0;
        tick();
        checks++; if (s_eat !== 2'b01 || s_food_valid !== 1'b0 || s_busy !== 1'b1) begin failures++; $display("FAIL full_eat eat=%b valid=%b busy=%b exp 01/0/1", s_eat, s_food_valid, s_busy); end
        n = 0;
        while (s_busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (n != 16) begin failures++; $display("FAIL giveup_cycles got=%0d exp=16", n); end
        checks++; if (s_food_valid !== 1'b0) begin failures++; $display("FAIL giveup_valid got=%b exp=0", s_food_valid); end
        s_len  = {4'd0, 4'd1};
        s_head = {3'd0, 3'd0};
        s_step = 1'b1;
        tick();
        s_step = 1'b0;
        n = 0;
        while (s_busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++; if (s_busy !== 1'b0 || s_food_valid !== 1'b1 || s_food_pos == 3'd0) begin failures++; $display("FAIL respawn busy=%b valid=%b pos=%0d exp 0/1/not 0", s_busy, s_food_valid, s_food_pos); end
        checks++; if (s_score !== 8'h01) begin failures++; $display("FAIL small_score got=%h exp=01", s_score); end
    endtask

    initial begin
        test_reset();
        test_eat();
        test_tie();
        test_back_to_back();
        test_saturate();
        test_giveup();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/food_manager.md
Name: food_manager

Overview:
- Multi-slot, multi-snake successor to the single-food checker.
- Owns NUM_FOOD food slots and NUM_SNAKE per-snake score registers on one clock.
- On each game step: detects heads landing on foods, credits scores, then runs a bounded LFSR search that respawns eaten slots on free board cells.
- Sits between the snake movement logic and the VGA renderer/scoreboard.

Parameters:
WIDTH, 32, board columns
HEIGHT, 24, board rows
POS_W, 10, linear cell index width; index = y*WIDTH+x
MAX_LEN, 15, body segments per snake
LEN_W, 4, width of length field and score
NUM_SNAKE, 2, number of snakes
NUM_FOOD, 2, number of food slots
MAX_TRIES, 64, LFSR candidates per slot before giving up
SEED, 16'hACE1, LFSR reset seed (nonzero)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
step  in  1  one-cycle game-step pulse
snake_body  in  NUM_SNAKE*MAX_LEN*POS_W  segment j of snake s at [(s*MAX_LEN+j)*POS_W +: POS_W]
snake_len  in  NUM_SNAKE*LEN_W  valid segment count per snake (segments 0..len-1)
snake_head  in  NUM_SNAKE*POS_W  head cell per snake
food_pos  out  NUM_FOOD*POS_W  food cell per slot
food_valid  out  NUM_FOOD  slot holds a placed food
score  out  NUM_SNAKE*LEN_W  per-snake score
eat_pulse  out  NUM_SNAKE  one-cycle pulse when snake s eats
busy  out  1  FSM not in IDLE
step_dropped  out  1  one-cycle pulse: step arrived while busy

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: food_pos 0, food_valid 0, score 0, eat_pulse 0, busy 0, step_dropped 0, pending mask all ones, try counter 0, LFSR = SEED, state IDLE.
- States: IDLE, CHECK, SEARCH.
- IDLE: step=1 -> CHECK. Otherwise, if pending!=0 -> SEARCH; this causes the initial spawn one cycle after reset release.
- CHECK (1 cycle):
  - For each valid slot f, eater = lowest s with snake_head[s]==food_pos[f].
  - Each eater's score +1, saturating at 2^LEN_W-1; eat_pulse[s]=1 for that cycle.
  - Eaten slots: valid<=0, pending<=1. Invalid slots from earlier give-ups are also set pending.
  - Next state: SEARCH if pending!=0, else IDLE.
- Score rules:
  - A snake eating two foods in one CHECK gets +2 (saturating).
  - Two heads on one food: only the lowest-index snake scores.
- SEARCH (one candidate per cycle):
  - cand = LFSR[POS_W-1:0].
  - cand is good iff: cand < WIDTH*HEIGHT; cand differs from every segment j<snake_len[s] of every snake; cand differs from every head; cand differs from food_pos of every valid slot.
  - Target slot = lowest pending index.
  - Good: food_pos<=cand, valid<=1, pending bit cleared, try counter<=0.
  - Bad: try counter +1. When the counter reaches MAX_TRIES-1 with no hit, clear the pending bit, leave valid=0, reset the counter.
  - Leave SEARCH when pending==0.
- LFSR advances every cycle regardless of state; it is not reset mid-game except by rst.
- busy=1 in CHECK and SEARCH. Inputs must be held stable while busy.
- step while busy is ignored; step_dropped pulses next cycle; no score change.
- rst mid-SEARCH: all state returns to reset values on that edge; a partially completed search is discarded.
- Worst-case latency step->IDLE: 1 + NUM_FOOD*MAX_TRIES cycles.
- Placement latency: minimum 2 cycles after CHECK for one slot.

Decomposition:
- Shared package food_pkg: STATE_IDLE/CHECK/SEARCH encodings; BOARD_CELLS = WIDTH*HEIGHT; field-slice helper for position and length indexing.
- One sub-module: lfsr_galois (16-bit Galois, taps 16,14,13,11; clk, rst, seed load on rst). It replaces the free-running lfsr and gives deterministic runs from SEED.
- Occupancy comparator is generate-loop logic inside food_manager; not a separate module.

Test Plan:
1. Reset release with both snakes len=3 in row 0 -> within 2*MAX_TRIES+2 cycles food_valid=2'b11; positions distinct, <768, not on any body cell; score=0.
2. Set snake_head[0]=food_pos[0], pulse step -> eat_pulse=2'b01 for one cycle, score0 0->1, food_valid[0] drops, then re-rises with a new position != old; food_pos[1] unchanged.
3. Both heads on food_pos[1], step -> only score0 increments; score1 unchanged; eat_pulse=2'b01.
4. score0 preloaded to 15 via repeated eats, one more eat -> score0 stays 15; eat_pulse[0] still pulses.
5. step asserted during SEARCH -> step_dropped=1 one cycle later; scores unchanged; search completes normally.
6. WIDTH=4, HEIGHT=2, MAX_LEN=8, MAX_TRIES=16; snake0 covers all 8 cells, step after an eat -> slot stays food_valid=0 after 16 SEARCH cycles; busy falls; a later step after freeing cells respawns it.
